// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program-counter register and instruction-fetch sequencer for a
// single-cycle core. Holds the architectural PC and presents it to
// instruction memory through a request/ready handshake. It captures the
// returned instruction word and advances to the branch-mux PC when the core
// commits.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a commit with PCin[1:0] != 0 is refused. The unit raises
//               fetch_err and parks in ERROR without moving the PC.
//   undefined : PCin is loaded verbatim, and its low bits reach imem_addr.

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCin,
    input  logic        advance,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PCout,
    output logic [31:0] PC_plus4,
    output logic [31:0] Instruction,
    output logic        inst_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2,
        ERROR      = 2'd3
    } state_t;

    // The counter value seen on the last waiting cycle before the timeout fires.
    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] instr_r, instr_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        req_r, req_nxt_s;
    logic        err_r, err_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;

    // Next-state and next-register-value logic; every register holds by default.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
        valid_nxt_s = valid_r;
        req_nxt_s   = req_r;
        err_nxt_s   = err_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            RESET_WAIT: begin
                // First clock out of reset starts fetching the reset PC.
                state_nxt_s = FETCH;
                req_nxt_s   = 1'b1;
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_nxt_s = imem_rdata;
                    valid_nxt_s = 1'b1;
                    cnt_nxt_s   = 8'd0;
                    req_nxt_s   = 1'b0;
                    state_nxt_s = HOLD;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    // Memory never answered: give up and latch the fault.
                    cnt_nxt_s   = cnt_r + 8'd1;
                    err_nxt_s   = 1'b1;
                    req_nxt_s   = 1'b0;
                    state_nxt_s = ERROR;
                end else begin
                    cnt_nxt_s   = cnt_r + 8'd1;
                end
            end
            HOLD: begin
                req_nxt_s = 1'b0;
                if (advance) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (PCin[1:0] != 2'b00) begin
                        // Misaligned target: keep the old PC and stop.
                        err_nxt_s   = 1'b1;
                        valid_nxt_s = 1'b0;
                        state_nxt_s = ERROR;
                    end else begin
                        pc_nxt_s    = PCin;
                        valid_nxt_s = 1'b0;
                        req_nxt_s   = 1'b1;
                        state_nxt_s = FETCH;
                    end
`else
                    pc_nxt_s    = PCin;
                    valid_nxt_s = 1'b0;
                    req_nxt_s   = 1'b1;
                    state_nxt_s = FETCH;
`endif
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            ERROR: begin
                // Terminal until reset; nothing further is requested.
                req_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
            end
            default: begin
                // An illegal encoding is treated as a fault.
                req_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
                err_nxt_s   = 1'b1;
                state_nxt_s = ERROR;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset discards any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_WAIT;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            valid_r <= 1'b0;
            req_r   <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            instr_r <= instr_nxt_s;
            valid_r <= valid_nxt_s;
            req_r   <= req_nxt_s;
            err_r   <= err_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign PCout       = pc_r;
    assign PC_plus4    = pc_r + 32'd4;
    assign Instruction = instr_r;
    assign inst_valid  = valid_r;
    assign fetch_err   = err_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit (RESET_PC = 0x40, FETCH_TIMEOUT = 16).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same time.

module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] PCin;
    logic        advance;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PCout;
    logic [31:0] PC_plus4;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic        fetch_err;

    int n_vec;
    int n_err;

    pc_fetch_unit #(
        .RESET_PC      (32'h0000_0040),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCin        (PCin),
        .advance     (advance),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .PCout       (PCout),
        .PC_plus4    (PC_plus4),
        .Instruction (Instruction),
        .inst_valid  (inst_valid),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across a few edges and release it just after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        advance    = 1'b0;
        PCin       = 32'h0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (PCout !== 32'h40) begin n_err++; $display("FAIL rst_pc: got %h want %h", PCout, 32'h40); end
        n_vec++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL rst_addr: got %h want %h", imem_addr, 32'h40); end
        n_vec++; if (PC_plus4 !== 32'h44) begin n_err++; $display("FAIL rst_plus4: got %h want %h", PC_plus4, 32'h44); end
        n_vec++; if ({imem_req, inst_valid, fetch_err} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {imem_req, inst_valid, fetch_err}); end
        n_vec++; if (Instruction !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", Instruction); end
        rst_n = 1'b1;
        tick();  // RESET_WAIT -> FETCH
        n_vec++; if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h40) begin n_err++; $display("FAIL first_fetch: req=%b valid=%b addr=%h want 1 0 40", imem_req, inst_valid, imem_addr); end
        tick();  // zero-wait memory -> HOLD
        n_vec++; if (inst_valid !== 1'b1 || Instruction !== 32'h1234_5678) begin n_err++; $display("FAIL first_instr: valid=%b instr=%h want 1 12345678", inst_valid, Instruction); end
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req: got %b want 0", imem_req); end
        imem_rdata = 32'hBAD0_BAD0;
        tick();  // ready in HOLD is ignored
        n_vec++; if (inst_valid !== 1'b1 || Instruction !== 32'h1234_5678 || PCout !== 32'h40) begin n_err++; $display("FAIL hold_keep: valid=%b instr=%h pc=%h want 1 12345678 40", inst_valid, Instruction, PCout); end
    endtask

    task automatic test_advance();
        imem_ready = 1'b0;
        PCin       = 32'h100;
        advance    = 1'b1;
        tick();
        advance = 1'b0;
        PCin    = 32'hDEAD_BEEF;
        n_vec++; if (PCout !== 32'h100 || inst_valid !== 1'b0) begin n_err++; $display("FAIL adv_pc: pc=%h valid=%b want 100 0", PCout, inst_valid); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL adv_req: req=%b addr=%h want 1 100", imem_req, imem_addr); end
        n_vec++; if (PC_plus4 !== 32'h104) begin n_err++; $display("FAIL adv_plus4: got %h want 104", PC_plus4); end
        tick();  // one wait state
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin n_err++; $display("FAIL adv_wait: req=%b addr=%h valid=%b want 1 100 0", imem_req, imem_addr, inst_valid); end
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0113;
        tick();
        imem_ready = 1'b0;
        n_vec++; if (inst_valid !== 1'b1 || Instruction !== 32'h0000_0113) begin n_err++; $display("FAIL adv_instr: valid=%b instr=%h want 1 00000113", inst_valid, Instruction); end
    endtask

    task automatic test_back_to_back();
        imem_ready = 1'b1;
        imem_rdata = 32'hCAFE_0001;
        advance    = 1'b1;
        PCin       = 32'h200;
        tick();
        n_vec++; if (PCout !== 32'h200 || inst_valid !== 1'b0 || imem_req !== 1'b1) begin n_err++; $display("FAIL b2b_fetch1: pc=%h valid=%b req=%b want 200 0 1", PCout, inst_valid, imem_req); end
        PCin = 32'h300;  // advance during FETCH must be ignored
        tick();
        n_vec++; if (PCout !== 32'h200 || inst_valid !== 1'b1 || Instruction !== 32'hCAFE_0001) begin n_err++; $display("FAIL b2b_hold1: pc=%h valid=%b instr=%h want 200 1 cafe0001", PCout, inst_valid, Instruction); end
        imem_rdata = 32'hCAFE_0002;
        tick();
        advance = 1'b0;
        n_vec++; if (PCout !== 32'h300 || inst_valid !== 1'b0) begin n_err++; $display("FAIL b2b_fetch2: pc=%h valid=%b want 300 0", PCout, inst_valid); end
        tick();
        imem_ready = 1'b0;
        n_vec++; if (PCout !== 32'h300 || inst_valid !== 1'b1 || Instruction !== 32'hCAFE_0002) begin n_err++; $display("FAIL b2b_hold2: pc=%h valid=%b instr=%h want 300 1 cafe0002", PCout, inst_valid, Instruction); end
    endtask

    task automatic test_wrap();
        PCin    = 32'hFFFF_FFFC;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        n_vec++; if (PCout !== 32'hFFFF_FFFC || PC_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4: pc=%h plus4=%h want fffffffc 0", PCout, PC_plus4); end
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_006F;
        tick();
        imem_ready = 1'b0;
        n_vec++; if (inst_valid !== 1'b1 || Instruction !== 32'h0000_006F) begin n_err++; $display("FAIL wrap_instr: valid=%b instr=%h want 1 0000006f", inst_valid, Instruction); end
        PCin    = PC_plus4;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        n_vec++; if (PCout !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_fetch0: pc=%h addr=%h req=%b want 0 0 1", PCout, imem_addr, imem_req); end
    endtask

    task automatic test_async_reset();
        repeat (3) tick();  // FETCH at 0 with wait states
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL ar_stable: req=%b addr=%h want 1 0", imem_req, imem_addr); end
        #2;
        rst_n = 1'b0;  // mid-cycle, no clock edge
        #1;
        n_vec++; if (PCout !== 32'h40 || imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0 || Instruction !== 32'h0) begin n_err++; $display("FAIL ar_async: pc=%h req=%b valid=%b err=%b instr=%h want 40 0 0 0 0", PCout, imem_req, inst_valid, fetch_err, Instruction); end
        imem_ready = 1'b1;  // discarded while reset is held
        imem_rdata = 32'hFEED_FACE;
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        n_vec++; if (inst_valid !== 1'b0 || Instruction !== 32'h0) begin n_err++; $display("FAIL ar_discard: valid=%b instr=%h want 0 0", inst_valid, Instruction); end
        rst_n = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0) begin n_err++; $display("FAIL ar_restart: req=%b addr=%h valid=%b want 1 40 0", imem_req, imem_addr, inst_valid); end
        imem_ready = 1'b1;
        imem_rdata = 32'h0400_0093;
        tick();
        imem_ready = 1'b0;
        n_vec++; if (inst_valid !== 1'b1 || Instruction !== 32'h0400_0093) begin n_err++; $display("FAIL ar_refetch: valid=%b instr=%h want 1 04000093", inst_valid, Instruction); end
    endtask

    task automatic test_timeout();
        int early;
        early      = 0;
        imem_ready = 1'b0;
        PCin       = 32'h500;
        advance    = 1'b1;
        tick();  // enter FETCH
        advance = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (fetch_err !== 1'b0 && early == 0) early = i;
        end
        n_vec++; if (early != 0) begin n_err++; $display("FAIL to_early: err rose after %0d cycles want 16", early); end
        tick();  // 16th cycle after FETCH entry
        n_vec++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL to_fire: err=%b req=%b want 1 0", fetch_err, imem_req); end
        imem_ready = 1'b1;
        imem_rdata = 32'h1111_2222;
        advance    = 1'b1;
        PCin       = 32'h600;
        repeat (3) tick();
        imem_ready = 1'b0;
        advance    = 1'b0;
        n_vec++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || PCout !== 32'h500) begin n_err++; $display("FAIL to_sticky: err=%b req=%b valid=%b pc=%h want 1 0 0 500", fetch_err, imem_req, inst_valid, PCout); end
    endtask

    task automatic test_align();
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0013;
        do_reset();
        tick();
        tick();  // HOLD at 0x40
        imem_ready = 1'b0;
        n_vec++; if (inst_valid !== 1'b1 || fetch_err !== 1'b0) begin n_err++; $display("FAIL al_pre: valid=%b err=%b want 1 0", inst_valid, fetch_err); end
        PCin    = 32'h102;
        advance = 1'b1;
        tick();
        advance = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        n_vec++; if (fetch_err !== 1'b1 || PCout !== 32'h40 || inst_valid !== 1'b0) begin n_err++; $display("FAIL al_trap: err=%b pc=%h valid=%b want 1 40 0", fetch_err, PCout, inst_valid); end
        repeat (2) tick();
        n_vec++; if (imem_req !== 1'b0 || PCout !== 32'h40) begin n_err++; $display("FAIL al_noreq: req=%b pc=%h want 0 40", imem_req, PCout); end
`else
        n_vec++; if (PCout !== 32'h102 || imem_addr !== 32'h102 || imem_req !== 1'b1) begin n_err++; $display("FAIL al_pass: pc=%h addr=%h req=%b want 102 102 1", PCout, imem_addr, imem_req); end
        n_vec++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL al_noerr: err=%b want 0", fetch_err); end
`endif
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        PCin       = 32'h0;
        advance    = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        test_reset();
        test_advance();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_timeout();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
